interval_bar_timer: RTL and testbench

Parametrised interval countdown timer with an LED bar display for the piano trainer. It loads a step count, decrements it once per prescaled tick, and drives an N-LED bar or dot indicator of the remaining steps. It pauses on request, optionally flashes the bar when a correct note is played, and emits a one-cycle `done` pulse at expiry. It sits between the game/interval controller and the LED pins.

---
 rtl/interval_bar_timer_pkg.sv | 31 +++
 rtl/tick_prescaler.sv | 30 +++
 rtl/interval_bar_timer.sv | 144 ++++++++++++++
 tb/tb_interval_bar_timer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_bar_timer_pkg.sv
// rtl/interval_bar_timer_pkg.sv - shared state enum, display modes and LED decode for interval_bar_timer
package interval_bar_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FLASH = 2'd3
   } state_t;

   localparam logic DISP_BAR = 1'b0;
   localparam logic DISP_DOT = 1'b1;
   localparam int   LED_MAX  = 32;

   // Bar fills from the MSB down; dot walks from the MSB (k=1) to bit 0 (k=n).
   function automatic logic [LED_MAX-1:0] led_decode(input int k, input int n, input logic mode);
      logic [LED_MAX-1:0] v;
      v = '0;
      for (int i = 0; i < LED_MAX; i++) begin
         if (i < n && k > 0) begin
            if (mode == DISP_DOT) begin
               v[i] = (k > n) ? (i == n - 1) : (i == n - k);
            end else begin
               v[i] = (k >= n) || (i >= n - k);
            end
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - cycle prescaler producing one tick per TICK_DIV enabled cycles
module tick_prescaler #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int W = $clog2(TICK_DIV);

   logic [W-1:0] r_cnt;
   logic         w_wrap;

   assign w_wrap = (r_cnt == W'(TICK_DIV - 1));
   assign o_tick = i_en & ~i_clr & w_wrap;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_wrap ? '0 : r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/interval_bar_timer.sv
// rtl/interval_bar_timer.sv - interval countdown timer with LED bar/dot display
// Correct-note flash is built only when INTERVAL_BAR_FLASH_EN is defined.
module interval_bar_timer #(
   parameter int N_LED        = 4,
   parameter int CNT_W        = 3,
   parameter int TICK_DIV     = 100_000_000,
   parameter int FLASH_CYCLES = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_load_value,
   input  logic             i_pause,
   input  logic             i_correct_note,
   input  logic             i_dot_mode,
   output logic [N_LED-1:0] o_led,
   output logic             o_busy,
   output logic             o_done
);
   import interval_bar_timer_pkg::*;

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [N_LED-1:0] r_led;
   logic             r_busy;
   logic             r_done;

   logic             w_tick;
   logic             w_note;
   logic             w_flash_last;
   logic             w_expire;
   logic [CNT_W-1:0] w_cnt_run;

   function automatic logic [N_LED-1:0] f_led(input logic [CNT_W-1:0] k, input logic mode);
      return N_LED'(led_decode(int'(k), N_LED, mode));
   endfunction

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (r_state == ST_RUN),
      .i_clr   (i_start),
      .o_tick  (w_tick)
   );

   assign w_expire  = w_tick && (r_count == CNT_W'(1));
   assign w_cnt_run = w_tick ? r_count - CNT_W'(1) : r_count;

`ifdef INTERVAL_BAR_FLASH_EN
   localparam int FL_W = $clog2(FLASH_CYCLES) + 1;
   logic [FL_W-1:0] r_flash_cnt;

   // Preloaded outside FLASH so the first FLASH cycle already holds the full length.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_flash_cnt <= FL_W'(FLASH_CYCLES - 1);
      end else if (r_state != ST_FLASH) begin
         r_flash_cnt <= FL_W'(FLASH_CYCLES - 1);
      end else if (r_flash_cnt != '0) begin
         r_flash_cnt <= r_flash_cnt - FL_W'(1);
      end
   end

   assign w_note       = i_correct_note;
   assign w_flash_last = (r_flash_cnt == '0);
`else
   logic w_unused_note;
   assign w_unused_note = i_correct_note;
   assign w_note        = 1'b0;
   assign w_flash_last  = 1'b1;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_led   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_count <= i_load_value;
            if (i_load_value == '0) begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_led   <= '0;
            end else begin
               r_state <= ST_RUN;
               r_busy  <= 1'b1;
               r_led   <= f_led(i_load_value, i_dot_mode);
            end
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (w_expire) begin
                     r_count <= '0;
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_led   <= '0;
                  end else begin
                     r_count <= w_cnt_run;
                     if (w_note) begin
                        r_state <= ST_FLASH;
                        r_led   <= '1;
                     end else begin
                        if (i_pause) r_state <= ST_HOLD;
                        r_led <= f_led(w_cnt_run, i_dot_mode);
                     end
                  end
               end
               ST_HOLD: begin
                  if (w_note) begin
                     r_state <= ST_FLASH;
                     r_led   <= '1;
                  end else begin
                     if (!i_pause) r_state <= ST_RUN;
                     r_led <= f_led(r_count, i_dot_mode);
                  end
               end
               ST_FLASH: begin
                  if (w_flash_last) begin
                     r_state <= i_pause ? ST_HOLD : ST_RUN;
                     r_led   <= f_led(r_count, i_dot_mode);
                  end else begin
                     r_led <= '1;
                  end
               end
               default: begin
                  r_led  <= '0;
                  r_busy <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_led  = r_led;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: tb/tb_interval_bar_timer.sv
// tb/tb_interval_bar_timer.sv - self-checking bench for interval_bar_timer against a count-of-run-cycles model
module tb_interval_bar_timer;
   localparam int N_LED        = 4;
   localparam int CNT_W        = 3;
   localparam int TICK_DIV     = 4;
   localparam int FLASH_CYCLES = 3;

   logic             clk   = 1'b0;
   logic             rst   = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] lv    = '0;
   logic             pause = 1'b0;
   logic             note  = 1'b0;
   logic             dot   = 1'b0;
   logic [N_LED-1:0] led;
   logic             busy;
   logic             done;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: remaining = load - (counted run cycles / TICK_DIV)
   bit   m_active;
   bit   m_paused;
   int   m_load;
   int   m_runs;
   int   m_flash;
   logic [N_LED-1:0] e_led;
   logic             e_busy;
   logic             e_done;

   always #5 clk = ~clk;

   interval_bar_timer #(
      .N_LED(N_LED), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .FLASH_CYCLES(FLASH_CYCLES)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_start        (start),
      .i_load_value   (lv),
      .i_pause        (pause),
      .i_correct_note (note),
      .i_dot_mode     (dot),
      .o_led          (led),
      .o_busy         (busy),
      .o_done         (done)
   );

   function automatic logic [3:0] ref_disp(input int k, input bit dm);
      int m;
      if (k <= 0) return 4'b0000;
      if (dm) return (k > 4) ? 4'b1000 : 4'(1 << (4 - k));
      m = (k > 4) ? 4 : k;
      return 4'(((1 << m) - 1) << (4 - m));
   endfunction

   task automatic model_reset();
      m_active = 0; m_paused = 0; m_load = 0; m_runs = 0; m_flash = 0;
      e_led = '0; e_busy = 0; e_done = 0;
   endtask

   task automatic model_step();
      bit note_eff;
`ifdef INTERVAL_BAR_FLASH_EN
      note_eff = note;
`else
      note_eff = 0;
`endif
      e_done = 0;
      if (start) begin
         m_load = int'(lv); m_runs = 0; m_flash = 0; m_paused = 0;
         m_active = (lv != 0);
         e_done = (lv == 0);
      end else if (m_active) begin
         if (m_flash > 0) begin
            m_flash--;
            if (m_flash == 0) m_paused = pause;
         end else if (!m_paused) begin
            m_runs++;
            if (m_load - m_runs / TICK_DIV == 0) begin
               m_active = 0;
               e_done = 1;
            end else if (note_eff) m_flash = FLASH_CYCLES;
            else if (pause) m_paused = 1;
         end else begin
            if (note_eff) m_flash = FLASH_CYCLES;
            else if (!pause) m_paused = 0;
         end
      end
      e_busy = m_active;
      e_led  = !m_active ? 4'b0000 :
               (m_flash > 0) ? 4'b1111 : ref_disp(m_load - m_runs / TICK_DIV, dot);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (led !== 4'b0000) begin n_fail++; $display("FAIL reset_led: got %b want 0000", led); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic test_bar_countdown();
      int done_at = -1;
      dot = 0; lv = 3; start = 1;
      cyc();
      start = 0;
      for (int i = 0; i <= 15; i++) begin
         if (i > 0) cyc();
         if (done === 1'b1 && done_at < 0) done_at = i;
         n_tests++;
         if (led !== e_led || busy !== e_busy || done !== e_done) begin
            n_fail++;
            $display("FAIL bar3 cyc %0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                     i, led, busy, done, e_led, e_busy, e_done);
         end
      end
      n_tests++;
      if (done_at != 12) begin n_fail++; $display("FAIL bar3_expiry: done at %0d want 12", done_at); end
   endtask

   task automatic test_saturate_and_zero();
      dot = 0; lv = 6; start = 1;
      cyc();
      start = 0;
      for (int i = 0; i < 26; i++) begin
         if (i > 0) cyc();
         n_tests++;
         if (led !== e_led || busy !== e_busy || done !== e_done) begin
            n_fail++;
            $display("FAIL sat6 cyc %0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                     i, led, busy, done, e_led, e_busy, e_done);
         end
      end
      lv = 0; start = 1;
      cyc();
      start = 0;
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || led !== 4'b0000) begin
         n_fail++;
         $display("FAIL zero_load: led=%b busy=%b done=%b want led=0000 busy=0 done=1", led, busy, done);
      end
      cyc();
      n_tests++;
      if (done !== 1'b0 || led !== 4'b0000) begin
         n_fail++;
         $display("FAIL zero_load_after: led=%b done=%b want led=0000 done=0", led, done);
      end
   endtask

   task automatic test_dot();
      dot = 1; lv = 4; start = 1;
      cyc();
      start = 0;
      for (int i = 0; i <= 17; i++) begin
         if (i > 0) cyc();
         n_tests++;
         if (led !== e_led || busy !== e_busy || done !== e_done) begin
            n_fail++;
            $display("FAIL dot4 cyc %0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                     i, led, busy, done, e_led, e_busy, e_done);
         end
      end
      dot = 0;
   endtask

   task automatic test_pause();
      int done_at = -1;
      lv = 2; start = 1;
      cyc();
      start = 0;
      for (int i = 1; i <= 24; i++) begin
         pause = (i >= 6 && i <= 15);
         cyc();
         if (done === 1'b1 && done_at < 0) done_at = i;
         n_tests++;
         if (led !== e_led || busy !== e_busy || done !== e_done) begin
            n_fail++;
            $display("FAIL pause cyc %0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                     i, led, busy, done, e_led, e_busy, e_done);
         end
      end
      pause = 0;
      n_tests++;
      if (done_at != 18) begin n_fail++; $display("FAIL pause_expiry: done at %0d want 18", done_at); end
   endtask

   task automatic test_flash();
      int n_full = 0;
      int exp_full;
`ifdef INTERVAL_BAR_FLASH_EN
      exp_full = FLASH_CYCLES;
`else
      exp_full = 0;
`endif
      lv = 3; start = 1;
      cyc();
      start = 0;
      for (int i = 1; i <= 22; i++) begin
         note  = (i == 3);
         pause = (i >= 3 && i <= 9);
         cyc();
         if (led === 4'b1111) n_full++;
         n_tests++;
         if (led !== e_led || busy !== e_busy || done !== e_done) begin
            n_fail++;
            $display("FAIL flash cyc %0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                     i, led, busy, done, e_led, e_busy, e_done);
         end
      end
      note = 0; pause = 0;
      n_tests++;
      if (n_full != exp_full) begin n_fail++; $display("FAIL flash_len: %0d full cycles want %0d", n_full, exp_full); end
      repeat (10) cyc();
      for (int i = 0; i < 4; i++) begin
         note = 1;
         cyc();
         n_tests++;
         if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL note_idle: led=%b busy=%b done=%b want 0000 0 0", led, busy, done);
         end
      end
      note = 0;
   endtask

   task automatic test_restart();
      int done_at = -1;
      lv = 5; start = 1;
      cyc();
      start = 0;
      repeat (6) cyc();
      lv = 2; start = 1;
      cyc();
      start = 0;
      for (int i = 0; i <= 10; i++) begin
         if (i > 0) cyc();
         if (done === 1'b1 && done_at < 0) done_at = i;
         n_tests++;
         if (led !== e_led || busy !== e_busy || done !== e_done) begin
            n_fail++;
            $display("FAIL restart cyc %0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                     i, led, busy, done, e_led, e_busy, e_done);
         end
      end
      n_tests++;
      if (done_at != 8) begin n_fail++; $display("FAIL restart_expiry: done at %0d want 8", done_at); end
   endtask

   task automatic test_reset_mid();
      lv = 3; start = 1;
      cyc();
      start = 0;
      repeat (5) cyc();
      @(negedge clk);
      #1 rst = 1;
      #1;
      n_tests++;
      if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: led=%b busy=%b done=%b want 0000 0 0", led, busy, done);
      end
      model_reset();
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 15; i++) begin
         cyc();
         n_tests++;
         if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after cyc %0d: led=%b busy=%b done=%b want 0000 0 0", i, led, busy, done);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         start = ($urandom_range(0, 19) == 0);
         lv    = CNT_W'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) pause = ~pause;
         note  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 9) == 0) dot = ~dot;
         cyc();
         n_tests++;
         if (led !== e_led || busy !== e_busy || done !== e_done) begin
            n_fail++;
            $display("FAIL random cyc %0d: led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                     i, led, busy, done, e_led, e_busy, e_done);
         end
      end
      start = 0; note = 0; pause = 0; dot = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_bar_countdown();
      test_saturate_and_zero();
      test_dot();
      test_pause();
      test_flash();
      test_restart();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
